hc_stream_reader: RTL and testbench

User-side read engine sitting directly upstream of the CCI-P requestor. It takes one transfer command (buffer id, start line, length in cache lines) and turns it into a sequence of single-line indexed read requests on the requestor's read-request port. It collects the read responses coming back on the requestor's rx data port into a local FIFO and presents them to the user core as a valid/ready stream with a last marker. Issue is credit-limited so that no response can ever overflow the local FIFO.

---
 rtl/hc_stream_reader.sv | 185 ++++++++++++++++++
 tb/tb_hc_stream_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_stream_reader.sv
// hc_stream_reader: turns one (id, offset, len) transfer command into single-line
// indexed read requests. Collects the responses in a local FIFO and streams them
// out with a last marker. Issue is credit-limited so responses never overflow the FIFO.
module hc_stream_reader #(
  parameter int DATA_W     = 512,
  parameter int ADDR_W     = 42,
  parameter int LEN_W      = 32,
  parameter int ID_W       = 4,
  parameter int CMD_W      = 3,
  parameter int CMD_NONE   = 0,
  parameter int CMD_RD_IDX = 2,
  parameter int FIFO_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ID_W-1:0]   start_id,
  input  logic [ADDR_W-1:0] start_offset,
  input  logic [LEN_W-1:0]  start_len,
  output logic              busy,
  output logic              done,
  output logic              err_unexp,
  output logic [CMD_W-1:0]  req_cmd,
  output logic [ID_W-1:0]   req_id,
  output logic [ADDR_W-1:0] req_offset,
  input  logic              req_full,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CMD_W-1:0] CMD_NONE_V = CMD_W'(CMD_NONE);
  localparam logic [CMD_W-1:0] CMD_RD_V   = CMD_W'(CMD_RD_IDX);
  localparam logic [LEN_W-1:0] DEPTH_V    = LEN_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [LEN_W-1:0]    recvd_q, recvd_d;
  logic [LEN_W-1:0]    popped_q, popped_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic [CMD_W-1:0]    req_cmd_q, req_cmd_d;
  logic [ID_W-1:0]     req_id_q, req_id_d;
  logic [ADDR_W-1:0]   req_offset_q, req_offset_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic [LEN_W-1:0]    outstanding;
  logic                has_credit;
  logic                push;
  logic                pop;

  // Credit is taken from registered state only; same-cycle pops are not counted back.
  assign outstanding = issued_q - recvd_q;
  assign has_credit  = (LEN_W'(count_q) + outstanding) < DEPTH_V;
  assign push        = rx_valid && (outstanding != '0);
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid && out_ready;

  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = done_q;
  assign err_unexp  = err_q;
  assign req_cmd    = req_cmd_q;
  assign req_id     = req_id_q;
  assign req_offset = req_offset_q;
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_last   = out_valid && (popped_q == len_q - LEN_W'(1));

  // Next-state, request issue, counters and FIFO pointers.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    base_d       = base_q;
    len_d        = len_q;
    issued_d     = issued_q;
    recvd_d      = push ? recvd_q + LEN_W'(1) : recvd_q;
    popped_d     = pop ? popped_q + LEN_W'(1) : popped_q;
    err_d        = err_q;
    done_d       = (state_q == S_DONE);
    req_cmd_d    = CMD_NONE_V;
    req_id_d     = req_id_q;
    req_offset_d = req_offset_q;
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          id_d     = start_id;
          base_d   = start_offset;
          len_d    = start_len;
          issued_d = '0;
          recvd_d  = '0;
          popped_d = '0;
          err_d    = 1'b0;
          if (start_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            // The first request leaves straight from IDLE to save a cycle.
            if (!req_full && has_credit) begin
              req_cmd_d    = CMD_RD_V;
              req_id_d     = start_id;
              req_offset_d = start_offset;
              issued_d     = LEN_W'(1);
            end
          end
        end
      end
      S_RUN: begin
        if (issued_q == len_q) begin
          state_d = S_DRAIN;
        end else if (!req_full && has_credit) begin
          req_cmd_d    = CMD_RD_V;
          req_id_d     = id_q;
          req_offset_d = base_q + ADDR_W'(issued_q);
          issued_d     = issued_q + LEN_W'(1);
        end
      end
      S_DRAIN: begin
        if (popped_d == len_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // A response with nothing outstanding is dropped and flagged.
    if (rx_valid && (outstanding == '0)) err_d = 1'b1;
  end

  // Control and counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      id_q         <= '0;
      base_q       <= '0;
      len_q        <= '0;
      issued_q     <= '0;
      recvd_q      <= '0;
      popped_q     <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      req_cmd_q    <= CMD_NONE_V;
      req_id_q     <= '0;
      req_offset_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      base_q       <= base_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      recvd_q      <= recvd_d;
      popped_q     <= popped_d;
      err_q        <= err_d;
      done_q       <= done_d;
      req_cmd_q    <= req_cmd_d;
      req_id_q     <= req_id_d;
      req_offset_q <= req_offset_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written, reads are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_hc_stream_reader.sv
// Bench for hc_stream_reader: acts as the requestor and the stream consumer and
// scoreboards the output stream against the responses it returned.
module tb_hc_stream_reader;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 42;
  localparam int LEN_W  = 32;
  localparam int ID_W   = 4;
  localparam int CMD_W  = 3;
  localparam int DEPTH  = 4;
  localparam logic [CMD_W-1:0] CMD_NONE = 3'd0;
  localparam logic [CMD_W-1:0] CMD_RD   = 3'd2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ID_W-1:0]   start_id;
  logic [ADDR_W-1:0] start_offset;
  logic [LEN_W-1:0]  start_len;
  logic              busy, done, err_unexp;
  logic [CMD_W-1:0]  req_cmd;
  logic [ID_W-1:0]   req_id;
  logic [ADDR_W-1:0] req_offset;
  logic              req_full;
  logic              rx_valid = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              out_valid, out_ready, out_last;
  logic [DATA_W-1:0] out_data;

  hc_stream_reader #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_id(start_id),
    .start_offset(start_offset), .start_len(start_len), .busy(busy), .done(done),
    .err_unexp(err_unexp), .req_cmd(req_cmd), .req_id(req_id), .req_offset(req_offset),
    .req_full(req_full), .rx_valid(rx_valid), .rx_data(rx_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] resp_data(input logic [ADDR_W-1:0] off);
    return {8{22'h2A5A5A, off}};
  endfunction

  typedef struct { int due; logic [ADDR_W-1:0] off; } pend_t;
  pend_t             pend[$];
  logic [DATA_W-1:0] exp_q[$];

  // Shared bookkeeping: written by the launch task, read by the monitor.
  logic [ID_W-1:0]   exp_id;
  logic [ADDR_W-1:0] exp_off;
  int cur_len = 0, req_base = 0, pop_base = 0, done_base = 0, busy_base = 0, t0 = 0;
  int rsp_delay = 0, spur_cnt = 0;
  // Monitor-owned counters.
  int req_cnt = 0, pop_cnt = 0, done_cnt = 0, busy_cnt = 0, spur_done = 0;
  int live = 0, max_occ = 0;
  int first_req_cyc = 0, last_req_cyc = 0, last_pop_cyc = 0, done_cyc = 0;

  // Requestor model and stream scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    pend_t e;
    logic [ADDR_W-1:0] want_off;
    logic [DATA_W-1:0] want;
    rx_valid = 1'b0;
    rx_data  = '0;
    if (!reset_n) begin
      pend.delete();
      exp_q.delete();
      live = 0;
    end else begin
      if (req_cmd == CMD_RD) begin
        want_off = exp_off + ADDR_W'(req_cnt - req_base);
        check_eq("req_offset", req_offset, want_off);
        check_eq("req_id", req_id, exp_id);
        if (req_cnt == req_base) first_req_cyc = cyc;
        last_req_cyc = cyc;
        req_cnt++;
        live++;
        pend.push_back('{due: cyc + rsp_delay, off: req_offset});
      end else begin
        check_eq("req_cmd_idle", req_cmd, CMD_NONE);
      end
      if (live > max_occ) max_occ = live;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        e = pend.pop_front();
        rx_valid = 1'b1;
        rx_data  = resp_data(e.off);
        exp_q.push_back(rx_data);
      end else if (spur_cnt != spur_done) begin
        spur_done++;
        rx_valid = 1'b1;
        rx_data  = '1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("stream_extra", exp_q.size(), 1);
        end else begin
          want = exp_q.pop_front();
          check_eq("out_data", out_data, want);
        end
        check_eq("out_last", out_last, (pop_cnt - pop_base) == cur_len - 1);
        pop_cnt++;
        live--;
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
    end
  end

  task automatic launch(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] off, input int len);
    exp_id = id; exp_off = off; cur_len = len;
    req_base = req_cnt; pop_base = pop_cnt; done_base = done_cnt; busy_base = busy_cnt;
    start = 1'b1; start_id = id; start_offset = off; start_len = LEN_W'(len);
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("done_seen", done_cnt - done_base, 1);
  endtask

  initial begin
    int snap;
    reset_n = 1'b0; start = 1'b0; start_id = '0; start_offset = '0; start_len = '0;
    req_full = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err_unexp, 0);
    check_eq("rst_req_cmd", req_cmd, CMD_NONE);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Basic transfer, responses 5 cycles after each request.
    out_ready = 1'b1; rsp_delay = 5;
    launch(4'd3, 42'h100, 4);
    wait_done(200);
    check_eq("t1_reqs", req_cnt - req_base, 4);
    check_eq("t1_pops", pop_cnt - pop_base, 4);
    check_eq("t1_first_req_cyc", first_req_cyc, t0 + 1);
    check_eq("t1_last_req_cyc", last_req_cyc, t0 + 4);
    check_eq("t1_done_latency", done_cyc, last_pop_cyc + 2);
    check_eq("t1_busy_after", busy, 0);
    repeat (3) @(posedge clk); #1;
    check_eq("t1_single_done", done_cnt - done_base, 1);

    // Zero-length transfer.
    launch(4'd1, 42'h0, 0);
    wait_done(20);
    check_eq("t2_done_cyc", done_cyc, t0 + 2);
    check_eq("t2_reqs", req_cnt - req_base, 0);
    check_eq("t2_busy", busy_cnt - busy_base, 0);

    // Credit stall with the consumer blocked, offsets wrapping past 2^ADDR_W.
    rsp_delay = 0; out_ready = 1'b0;
    launch(4'd5, 42'h3FF_FFFF_FFFE, 10);
    repeat (20) @(posedge clk); #1;
    check_eq("t3_stall_reqs", req_cnt - req_base, DEPTH);
    check_eq("t3_stall_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_done(300);
    check_eq("t3_reqs", req_cnt - req_base, 10);
    check_eq("t3_pops", pop_cnt - pop_base, 10);
    check_eq("t3_max_occ", max_occ, DEPTH);

    // req_full back-pressure for 20 cycles mid-transfer.
    rsp_delay = 2;
    launch(4'd7, 42'h500, 8);
    @(posedge clk); #1;
    req_full = 1'b1;
    @(posedge clk); #1;
    snap = req_cnt;
    check_eq("t4_pre_full", req_cnt - req_base, 2);
    repeat (19) @(posedge clk); #1;
    check_eq("t4_full_hold", req_cnt, snap);
    req_full = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    check_eq("t4_resume", req_cnt, snap + 1);
    wait_done(300);
    check_eq("t4_reqs", req_cnt - req_base, 8);
    check_eq("t4_pops", pop_cnt - pop_base, 8);

    // Unexpected response while idle.
    repeat (2) @(posedge clk); #1;
    spur_cnt++;
    @(posedge clk); #1;
    check_eq("t5_err_set", err_unexp, 1);
    check_eq("t5_no_valid", out_valid, 0);
    @(posedge clk); #1;
    check_eq("t5_err_sticky", err_unexp, 1);
    check_eq("t5_no_valid2", out_valid, 0);
    launch(4'd1, 42'h40, 1);
    check_eq("t5_err_cleared", err_unexp, 0);
    wait_done(100);
    check_eq("t5_pops", pop_cnt - pop_base, 1);

    // Asynchronous reset mid-transfer, then a normal transfer.
    rsp_delay = 10;
    launch(4'd2, 42'h300, 8);
    repeat (2) @(posedge clk); #1;
    check_eq("t6_mid_busy", busy, 1);
    @(negedge clk); #2;
    check_eq("t6_outstanding", req_cnt - req_base, 3);
    reset_n = 1'b0;
    #1;
    check_eq("t6_busy", busy, 0);
    check_eq("t6_done", done, 0);
    check_eq("t6_err", err_unexp, 0);
    check_eq("t6_req_cmd", req_cmd, CMD_NONE);
    check_eq("t6_req_id", req_id, 0);
    check_eq("t6_req_offset", req_offset, 0);
    check_eq("t6_out_valid", out_valid, 0);
    check_eq("t6_out_last", out_last, 0);
    check_eq("t6_out_data", out_data, 0);
    @(negedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    rsp_delay = 1;
    launch(4'd9, 42'h200, 2);
    wait_done(100);
    check_eq("t6_reqs", req_cnt - req_base, 2);
    check_eq("t6_pops", pop_cnt - pop_base, 2);
    check_eq("t6_busy_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d required completion", cyc);
    $fatal(1);
  end
endmodule
